// File: rtl/sdram_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-request SDRAM host.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the data port always wins.
module sdram_arbiter #(
    parameter int unsigned WAIT_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    // instruction port (read-only)
    input  logic        i_access,
    input  logic [31:2] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    // data port
    input  logic        d_access,
    input  logic [31:2] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    // SDRAM host request
    output logic        cs,
    output logic [31:2] h_addr,
    output logic [31:0] h_wdata,
    output logic        h_wr_en,
    output logic [3:0]  h_bytesel,
    // SDRAM host response
    input  logic [31:0] h_rdata,
    input  logic        h_compl,
    input  logic        h_config_done,
    output logic        busy
);

    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic          r_gnt_d;
    logic          w_grant, w_pick_d, w_done, w_timeout, w_wait_expired;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // Tie goes to whichever port was not served last.
    always_comb w_pick_d = d_access && (!i_access || !r_last_d);

    always_ff @(posedge clk) begin
        if (rst)          r_last_d <= 1'b1;
        else if (w_grant) r_last_d <= w_pick_d;
    end
`else
    always_comb w_pick_d = d_access;
`endif

    assign w_wait_expired = (32'(r_wait_cnt) + 32'd1) >= WAIT_TIMEOUT;
    assign busy           = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (h_config_done && (i_access || d_access)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (h_compl) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_wait_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs         <= 1'b0;
            h_addr     <= '0;
            h_wdata    <= '0;
            h_wr_en    <= 1'b0;
            h_bytesel  <= '0;
            r_gnt_d    <= 1'b0;
            r_wait_cnt <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            // cs is high exactly while the FSM sits in ISSUE
            cs <= w_grant;

            if (w_grant) begin
                r_gnt_d   <= w_pick_d;
                h_addr    <= w_pick_d ? d_addr : i_addr;
                h_wdata   <= w_pick_d ? d_wdata : 32'd0;
                h_wr_en   <= w_pick_d & d_wr_en;
                h_bytesel <= w_pick_d ? d_bytesel : 4'b1111;
            end

            if (r_state == WAIT && w_state_nxt == WAIT) r_wait_cnt <= r_wait_cnt + CW'(1);
            else                                        r_wait_cnt <= '0;

            if (w_done || w_timeout) begin
                i_ack   <= !r_gnt_d;
                d_ack   <= r_gnt_d;
                i_err   <= !r_gnt_d && w_timeout;
                d_err   <= r_gnt_d && w_timeout;
                i_rdata <= (!r_gnt_d && w_done && !h_wr_en) ? h_rdata : 32'd0;
                d_rdata <= (r_gnt_d && w_done && !h_wr_en) ? h_rdata : 32'd0;
            end else if (r_state == RESP) begin
                // response is only valid alongside its ack
                i_ack   <= 1'b0;
                d_ack   <= 1'b0;
                i_err   <= 1'b0;
                d_err   <= 1'b0;
                i_rdata <= '0;
                d_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small byte-enable SDRAM host model.
module tb_sdram_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_access = 1'b0, d_access = 1'b0, d_wr_en = 1'b0;
    logic [31:2] i_addr = '0, d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_bytesel = '0;
    logic [31:0] i_rdata, d_rdata, h_wdata;
    logic        i_ack, i_err, d_ack, d_err, cs, h_wr_en, busy;
    logic [31:2] h_addr;
    logic [3:0]  h_bytesel;
    logic [31:0] h_rdata = '0;
    logic        h_compl = 1'b0;
    logic        h_config_done = 1'b0;

    always #5 clk = ~clk;

    sdram_arbiter #(.WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_access(i_access), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_access(d_access), .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_en(d_wr_en),
        .d_bytesel(d_bytesel), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .cs(cs), .h_addr(h_addr), .h_wdata(h_wdata), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel),
        .h_rdata(h_rdata), .h_compl(h_compl), .h_config_done(h_config_done), .busy(busy)
    );

    int checks = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Host model: answers a cs request with h_compl one cycle later.
    logic [31:0] mem [0:255];
    bit          mem_ok [0:255];
    bit          resp_en = 1'b1, force_compl = 1'b0;
    int          cs_cnt = 0;
    logic        last_wr;
    logic [3:0]  last_bs;
    logic [31:0] last_wd;

    always @(posedge clk) begin
        bit          hit;
        logic [7:0]  ix;
        logic [31:0] cur;
        hit = (cs === 1'b1) && resp_en;
        ix  = h_addr[9:2];
        cur = mem_ok[ix] ? mem[ix] : (32'hC0DE0000 | 32'(ix));
        if (cs === 1'b1) begin
            cs_cnt++;
            last_wr = h_wr_en;
            last_bs = h_bytesel;
            last_wd = h_wdata;
        end
        #1;
        h_compl = hit || force_compl;
        h_rdata = '0;
        if (hit) begin
            if (last_wr) begin
                for (int b = 0; b < 4; b++)
                    if (last_bs[b]) cur[8*b +: 8] = last_wd[8*b +: 8];
                mem[ix]    = cur;
                mem_ok[ix] = 1'b1;
            end else begin
                h_rdata = cur;
            end
        end
    end

    task automatic xact(input bit use_d, input logic [29:0] a, input bit wr,
                        input logic [31:0] wd, input logic [3:0] bs,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int cs_seen, output bit other);
        int c0;
        @(negedge clk);
        c0 = cs_cnt;
        if (use_d) begin
            d_addr = a; d_wr_en = wr; d_wdata = wd; d_bytesel = bs; d_access = 1'b1;
        end else begin
            i_addr = a; i_access = 1'b1;
        end
        lat = -1; rd = '0; er = 1'b0; other = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (use_d ? (i_ack || i_err || i_rdata != 0) : (d_ack || d_err || d_rdata != 0)) other = 1'b1;
            if (use_d ? d_ack : i_ack) begin
                lat = n;
                rd  = use_d ? d_rdata : i_rdata;
                er  = use_d ? d_err : i_err;
                break;
            end
        end
        i_access = 1'b0; d_access = 1'b0; d_wr_en = 1'b0;
        cs_seen = cs_cnt - c0;
    endtask

    int          lat, cs_seen, cnt, nack, last_n;
    logic [31:0] rd;
    logic        er;
    bit          other;
    logic [3:0]  seq;
    logic        first_d;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({cs, busy, i_ack, d_ack, i_err, d_err, h_wr_en}), 32'd0);
        chk("rst_data", i_rdata | d_rdata | h_wdata | 32'(h_addr) | 32'(h_bytesel), 32'd0);
        rst = 1'b0;

        // config gating
        i_addr = 30'h10; i_access = 1'b1; cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (cs) cnt++;
            if (busy) cnt++;
        end
        chk("cfg_gate_cs", 32'(cnt), 32'd0);
        h_config_done = 1'b1;
        @(negedge clk);
        chk("cfg_first_cs", 32'(cs), 32'd1);
        chk("cfg_i_fields", {27'd0, h_wr_en, h_bytesel}, {27'd0, 1'b0, 4'b1111});
        @(negedge clk);
        chk("cfg_cs_drop", 32'(cs), 32'd0);
        @(negedge clk);
        chk("cfg_ack", 32'({i_ack, d_ack}), 32'b10);
        chk("cfg_rdata", i_rdata, 32'hC0DE0010);
        i_access = 1'b0;

        // data write then instruction read of 0x100
        xact(1'b1, 30'h40, 1'b1, 32'hDEADBEEF, 4'b1111, lat, rd, er, cs_seen, other);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_rdata", rd, 32'd0);
        chk("wr_cs_cnt", 32'(cs_seen), 32'd1);
        xact(1'b0, 30'h40, 1'b0, 32'd0, 4'd0, lat, rd, er, cs_seen, other);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_cs_cnt", 32'(cs_seen), 32'd1);
        chk("rd_other_quiet", 32'(other), 32'd0);
        chk("i_grant_fields", {last_wd[30:0], last_wr} ^ {27'd0, last_bs, 1'b0}, {27'd0, 4'b1111, 1'b0});

        // byte write to 0x104, read back on the data port
        xact(1'b1, 30'h41, 1'b1, 32'h0000AB00, 4'b0010, lat, rd, er, cs_seen, other);
        chk("bw_bytesel", 32'(last_bs), 32'h2);
        xact(1'b1, 30'h41, 1'b0, 32'd0, 4'b1111, lat, rd, er, cs_seen, other);
        chk("bw_readback", rd, 32'hC0DEAB41);
        chk("bw_err", 32'(er), 32'd0);

        // contention, last grant was data
        @(negedge clk);
        i_addr = 30'h20; d_addr = 30'h30; d_wr_en = 1'b0;
        i_access = 1'b1; d_access = 1'b1;
        seq = '0; nack = 0; last_n = -1; cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                seq[nack] = d_ack;
                if (d_ack) cnt++;
                nack++;
                last_n = n;
`ifndef SDRAM_ARB_ROUND_ROBIN_EN
                if (cnt == 3) d_access = 1'b0;
`endif
                if (nack == 4) break;
            end
        end
        i_access = 1'b0; d_access = 1'b0;
        chk("cont_nack", 32'(nack), 32'd4);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        chk("cont_seq", 32'(seq), 32'b1010);
`else
        chk("cont_seq", 32'(seq), 32'b0111);
`endif
        chk("cont_spacing", 32'(last_n), 32'd15);

        // h_compl while idle is ignored
        @(negedge clk);
        force_compl = 1'b1;
        @(negedge clk);
        force_compl = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack || busy) cnt++;
        end
        chk("idle_compl_ignored", 32'(cnt), 32'd0);

        // timeout
        resp_en = 1'b0;
        xact(1'b0, 30'h22, 1'b0, 32'd0, 4'd0, lat, rd, er, cs_seen, other);
        chk("to_lat", 32'(lat), 32'(TO + 2));
        chk("to_err", 32'(er), 32'd1);
        chk("to_rdata", rd, 32'd0);
        @(negedge clk);
        chk("to_idle", 32'({busy, i_ack, i_err}), 32'd0);

        // reset mid-WAIT on an instruction transfer, then a late h_compl
        @(negedge clk);
        i_addr = 30'h23; i_access = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_busy", 32'({busy, cs}), 32'b10);
        rst = 1'b1; i_access = 1'b0;
        @(negedge clk);
        rst = 1'b0; force_compl = 1'b1;
        @(negedge clk);
        force_compl = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (i_ack || d_ack || i_err || d_err || busy || cs) cnt++;
        end
        chk("rst_mid_no_ack", 32'(cnt), 32'd0);
        chk("rst_mid_zero", i_rdata | d_rdata | h_wdata | 32'(h_addr) | 32'({h_wr_en, h_bytesel}), 32'd0);
        resp_en = 1'b1;

        // first tie after reset
        @(negedge clk);
        i_addr = 30'h24; d_addr = 30'h25; i_access = 1'b1; d_access = 1'b1;
        first_d = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                first_d = d_ack;
                break;
            end
        end
        i_access = 1'b0; d_access = 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        chk("tie_after_reset", 32'(first_d), 32'd0);
`else
        chk("tie_after_reset", 32'(first_d), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
